// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// instr_sequencer: fetch/execute sequencer for the 16-bit core.
// Fetches each instruction as two bytes over the shared 8-bit memory bus.
// Holds it in ir for the decoder, then sequences the optional phases:
// extension-word fetch, data transfers, execute strobe and PC update.
// This block is the sole master of the memory bus.
//
// Bus handshake: mem_req acts as valid and mem_ack as ready. A byte moves on
// the rising edge where mem_req && mem_ack. While mem_req is high and mem_ack
// is low, mem_req, mem_addr and mem_we hold their values. mem_ack may be
// high in the same cycle that mem_req first rises (zero-wait memory).
module instr_sequencer #(
  parameter logic [15:0] RESET_PC            = 16'h0000,
  parameter int          MEM_BYTES           = 1,
  parameter int          STACK_BYTES         = 2,
  // Decoder operator_group encodings; these must match the decoder's table.
  parameter logic [3:0]  GROUP_SPECIAL_LONG  = 4'hC,
  parameter logic [3:0]  GROUP_WRRMATH_MEM   = 4'hA,
  parameter logic [3:0]  GROUP_WRSMATH_STACK = 4'hB
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] ir,
  output logic [15:0] ext_word,
  input  logic [3:0]  operator_group,
  output logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic        data_we,
  output logic [1:0]  data_idx,
  output logic        data_strobe,
  output logic        exec_en,
  input  logic        pc_load,
  input  logic [15:0] pc_value,
  input  logic        halt,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH_LO = 3'd0,
    S_FETCH_HI = 3'd1,
    S_DECODE   = 3'd2,
    S_EXT_LO   = 3'd3,
    S_EXT_HI   = 3'd4,
    S_DATA     = 3'd5,
    S_EXEC     = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  // Index of the final byte of each data phase.
  localparam logic [1:0] MEM_LAST   = 2'(MEM_BYTES - 1);
  localparam logic [1:0] STACK_LAST = 2'(STACK_BYTES - 1);

  state_t     state;
  logic       data_stack;  // current data phase is a stack transfer
  logic       bus_state;
  logic [1:0] data_last;

  assign state_dbg = state;
  assign data_last = data_stack ? STACK_LAST : MEM_LAST;

  // Bus and strobe outputs decode directly from the state register.
  // Reset gates them so the bus drops immediately on an asynchronous reset.
  always_comb begin
    bus_state   = (state == S_FETCH_LO) || (state == S_FETCH_HI) ||
                  (state == S_EXT_LO)   || (state == S_EXT_HI)   ||
                  (state == S_DATA);
    mem_req     = !reset && bus_state;
    mem_addr    = (state == S_DATA) ? (data_addr + {14'd0, data_idx}) : pc;
    mem_we      = !reset && (state == S_DATA) && data_we;
    data_strobe = !reset && (state == S_DATA) && mem_ack;
    exec_en     = !reset && (state == S_EXEC);
  end

  // Sequencer FSM with pc, ir, ext_word and data index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH_LO;
      pc         <= RESET_PC;
      ir         <= 16'h0000;
      ext_word   <= 16'h0000;
      data_idx   <= 2'd0;
      data_stack <= 1'b0;
    end else begin
      case (state)
        S_FETCH_LO: begin
          if (mem_ack) begin
            ir[7:0] <= mem_rdata;
            pc      <= pc + 16'd1;
            state   <= S_FETCH_HI;
          end
        end
        S_FETCH_HI: begin
          if (mem_ack) begin
            ir[15:8] <= mem_rdata;
            pc       <= pc + 16'd1;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Decoder output has had a full cycle to settle on the new ir.
          if (operator_group == GROUP_SPECIAL_LONG) begin
            state <= S_EXT_LO;
          end else if (operator_group == GROUP_WRRMATH_MEM) begin
            data_stack <= 1'b0;
            state      <= S_DATA;
          end else if (operator_group == GROUP_WRSMATH_STACK) begin
            data_stack <= 1'b1;
            state      <= S_DATA;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXT_LO: begin
          if (mem_ack) begin
            ext_word[7:0] <= mem_rdata;
            pc            <= pc + 16'd1;
            state         <= S_EXT_HI;
          end
        end
        S_EXT_HI: begin
          if (mem_ack) begin
            ext_word[15:8] <= mem_rdata;
            pc             <= pc + 16'd1;
            state          <= S_EXEC;
          end
        end
        S_DATA: begin
          if (mem_ack) begin
            if (data_idx == data_last) begin
              data_idx <= 2'd0;
              state    <= S_EXEC;
            end else begin
              data_idx <= data_idx + 2'd1;
            end
          end
        end
        S_EXEC: begin
          // A taken branch replaces the already-incremented pc.
          if (pc_load) begin
            pc <= pc_value;
          end
          state <= halt ? S_HALT : S_FETCH_LO;
        end
        S_HALT: begin
          if (!halt) begin
            state <= S_FETCH_LO;
          end
        end
        default: state <= S_FETCH_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
// Testbench for instr_sequencer: byte memory with programmable wait states,
// a bus-transaction scoreboard, and an instruction-level reference model
// that predicts latency, ir/ext_word, pc and data strobes per instruction.
module tb_instr_sequencer;

  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam int          MEM_BYTES   = 1;
  localparam int          STACK_BYTES = 2;
  localparam logic [3:0]  G_PLAIN     = 4'h2;
  localparam logic [3:0]  G_LONG      = 4'hC;
  localparam logic [3:0]  G_MEM       = 4'hA;
  localparam logic [3:0]  G_STACK     = 4'hB;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [15:0] ir;
  logic [15:0] ext_word;
  logic [3:0]  operator_group;
  logic [15:0] pc;
  logic [15:0] data_addr;
  logic        data_we;
  logic [1:0]  data_idx;
  logic        data_strobe;
  logic        exec_en;
  logic        pc_load;
  logic [15:0] pc_value;
  logic        halt;
  logic [2:0]  state_dbg;

  logic [7:0]  mem [0:65535];
  int          wait_cfg;
  int          wait_cnt;
  int          checks;
  int          errors;
  logic [16:0] exp_q[$];   // {we, addr} of each expected bus transfer
  logic [16:0] exp_t;
  logic        hold_v;
  logic [15:0] hold_addr;
  logic        hold_we;
  logic [15:0] model_ext;

  typedef struct {
    int          cycles;
    logic [15:0] ir;
    logic [15:0] ext;
    logic [15:0] pc_exec;
    logic [15:0] pc_next;
    int          strobes;
  } exp_t_s;

  typedef struct {
    int          cycles;
    logic [15:0] ir;
    logic [15:0] ext;
    logic [15:0] pc;
    int          strobes;
    logic [7:0]  idx_seq;
    logic [1:0]  idx_exec;
  } obs_t;

  instr_sequencer #(
    .RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES), .STACK_BYTES(STACK_BYTES),
    .GROUP_SPECIAL_LONG(G_LONG), .GROUP_WRRMATH_MEM(G_MEM),
    .GROUP_WRSMATH_STACK(G_STACK)
  ) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_rdata(mem_rdata), .ir(ir),
    .ext_word(ext_word), .operator_group(operator_group), .pc(pc),
    .data_addr(data_addr), .data_we(data_we), .data_idx(data_idx),
    .data_strobe(data_strobe), .exec_en(exec_en), .pc_load(pc_load),
    .pc_value(pc_value), .halt(halt), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench decoder: instruction class chosen by the low nibble of ir.
  function automatic logic [3:0] decode_group(input logic [15:0] w);
    case (w[3:0])
      4'hB:    return G_LONG;
      4'hD:    return G_MEM;
      4'hF:    return G_STACK;
      default: return G_PLAIN;
    endcase
  endfunction

  assign operator_group = decode_group(ir);
  assign mem_ack        = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata      = mem[mem_addr];

  // Memory wait-state counter: ack after wait_cfg stalled cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Bus monitor: request stability while stalled, and transfer scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!mem_req || mem_addr !== hold_addr || mem_we !== hold_we) begin
          errors++;
          $display("FAIL bus_hold: req=%b addr=%h we=%b, required req=1 addr=%h we=%b",
                   mem_req, mem_addr, mem_we, hold_addr, hold_we);
        end
      end
      if (mem_req && mem_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_txn: unexpected transfer we=%b addr=%h", mem_we, mem_addr);
        end else begin
          exp_t = exp_q.pop_front();
          if ({mem_we, mem_addr} !== exp_t) begin
            errors++;
            $display("FAIL bus_txn: got we=%b addr=%h, required we=%b addr=%h",
                     mem_we, mem_addr, exp_t[16], exp_t[15:0]);
          end
        end
        hold_v = 1'b0;
      end else if (mem_req) begin
        hold_v    = 1'b1;
        hold_addr = mem_addr;
        hold_we   = mem_we;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Reset the DUT and all bench state; returns just after release.
  task automatic do_reset();
    reset = 1'b1; halt = 1'b0; pc_load = 1'b0; pc_value = 16'h0000;
    wait_cfg = 0; data_addr = 16'h0000; data_we = 1'b0;
    exp_q.delete(); model_ext = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Reference model: places the instruction in memory, queues its bus
  // transfers and predicts the instruction-level results.
  task automatic plan_instr(input logic [15:0] pc0, input logic [15:0] word,
                            input logic [15:0] ext_in, input int w,
                            input logic [15:0] da, input logic dwe,
                            input logic load, input logic [15:0] lval,
                            output exp_t_s e);
    logic [15:0] p;
    int bytes;
    int n;
    p = pc0; bytes = 2; n = 0;
    mem[p] = word[7:0];  exp_q.push_back({1'b0, p}); p = p + 16'd1;
    mem[p] = word[15:8]; exp_q.push_back({1'b0, p}); p = p + 16'd1;
    if (word[3:0] == 4'hB) begin
      mem[p] = ext_in[7:0];  exp_q.push_back({1'b0, p}); p = p + 16'd1;
      mem[p] = ext_in[15:8]; exp_q.push_back({1'b0, p}); p = p + 16'd1;
      bytes = 4;
      model_ext = ext_in;
    end else if (word[3:0] == 4'hD) begin
      n = MEM_BYTES;
    end else if (word[3:0] == 4'hF) begin
      n = STACK_BYTES;
    end
    for (int i = 0; i < n; i++) exp_q.push_back({dwe, da + 16'(i)});
    e.cycles  = (bytes + n) * (w + 1) + 2;
    e.ir      = word;
    e.ext     = model_ext;
    e.pc_exec = p;
    e.pc_next = load ? lval : p;
    e.strobes = n;
    wait_cfg = w; data_addr = da; data_we = dwe; pc_load = load; pc_value = lval;
  endtask

  // Run until the execute pulse (bounded), then step past the EXEC edge.
  task automatic observe(output obs_t o);
    logic [7:0] seq;
    int ns;
    seq = 8'h00; ns = 0;
    o.cycles = -1; o.ir = 16'h0; o.ext = 16'h0; o.pc = 16'h0; o.idx_exec = 2'd0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (data_strobe === 1'b1) begin
        if (ns < 4) seq[2*ns +: 2] = data_idx;
        ns++;
      end
      if (exec_en === 1'b1) begin
        o.cycles = c; o.ir = ir; o.ext = ext_word; o.pc = pc; o.idx_exec = data_idx;
        break;
      end
    end
    o.strobes = ns; o.idx_seq = seq;
    @(posedge clk);
    #1 pc_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || exec_en !== 1'b0 || data_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b exec=%b strobe=%b, required all 0",
               mem_req, mem_we, exec_en, data_strobe);
    end
    checks++;
    if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h required %h", pc, RESET_PC); end
    checks++;
    if (ir !== 16'h0 || ext_word !== 16'h0 || data_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs: ir=%h ext=%h idx=%0d, required 0", ir, ext_word, data_idx);
    end
  endtask

  task automatic test_plain();
    exp_t_s e; obs_t o;
    do_reset();
    plan_instr(RESET_PC, 16'h0010, 16'h0, 0, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.cycles !== 4) begin errors++; $display("FAIL plain_latency: got %0d required 4", o.cycles); end
    checks++;
    if (o.ir !== 16'h0010) begin errors++; $display("FAIL plain_ir: got %h required 0010", o.ir); end
    checks++;
    if (pc !== 16'h0002) begin errors++; $display("FAIL plain_pc: got %h required 0002", pc); end
  endtask

  task automatic test_wait_states();
    exp_t_s e; obs_t o;
    do_reset();
    plan_instr(RESET_PC, 16'hA5C2, 16'h0, 3, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.cycles !== 10) begin errors++; $display("FAIL wait_latency: got %0d required 10", o.cycles); end
    checks++;
    if (o.ir !== 16'hA5C2) begin errors++; $display("FAIL wait_ir: got %h required a5c2", o.ir); end
  endtask

  task automatic test_special_long();
    exp_t_s e; obs_t o;
    do_reset();
    plan_instr(RESET_PC, 16'hE01B, 16'h1234, 0, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.cycles !== 6) begin errors++; $display("FAIL long_latency: got %0d required 6", o.cycles); end
    checks++;
    if (o.ext !== 16'h1234 || o.ir !== 16'hE01B) begin
      errors++; $display("FAIL long_words: ir=%h ext=%h, required e01b 1234", o.ir, o.ext);
    end
    checks++;
    if (o.pc !== 16'h0004) begin errors++; $display("FAIL long_pc: got %h required 0004", o.pc); end
  endtask

  task automatic test_mem_write();
    exp_t_s e; obs_t o;
    do_reset();
    plan_instr(RESET_PC, 16'h801D, 16'h0, 0, 16'h0200, 1'b1, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.strobes !== 1) begin errors++; $display("FAIL mem_strobes: got %0d required 1", o.strobes); end
    checks++;
    if (o.cycles !== 5) begin errors++; $display("FAIL mem_latency: got %0d required 5", o.cycles); end
  endtask

  task automatic test_stack_wrap();
    exp_t_s e; obs_t o;
    do_reset();
    plan_instr(RESET_PC, 16'hE01F, 16'h0, 0, 16'hFFFF, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.strobes !== 2 || o.idx_seq !== 8'h04) begin
      errors++; $display("FAIL stack_idx: strobes=%0d seq=%h, required 2 04", o.strobes, o.idx_seq);
    end
    checks++;
    if (o.idx_exec !== 2'd0) begin errors++; $display("FAIL stack_idx_clear: got %0d required 0", o.idx_exec); end
    checks++;
    if (o.cycles !== 6) begin errors++; $display("FAIL stack_latency: got %0d required 6", o.cycles); end
  endtask

  task automatic test_pc_load();
    exp_t_s e; obs_t o;
    do_reset();
    plan_instr(RESET_PC, 16'h0010, 16'h0, 0, 16'h0, 1'b0, 1'b1, 16'hFFFE, e);
    observe(o);
    plan_instr(16'hFFFE, 16'h3302, 16'h0, 0, 16'h0, 1'b0, 1'b1, 16'h0100, e);
    observe(o);
    checks++;
    if (o.pc !== 16'h0000 || o.ir !== 16'h3302) begin
      errors++; $display("FAIL load_exec: pc=%h ir=%h, required 0000 3302", o.pc, o.ir);
    end
    checks++;
    if (pc !== 16'h0100) begin errors++; $display("FAIL load_pc: got %h required 0100", pc); end
    plan_instr(16'h0100, 16'h7744, 16'h0, 0, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.ir !== 16'h7744 || o.cycles !== 4) begin
      errors++; $display("FAIL load_fetch: ir=%h cycles=%0d, required 7744 4", o.ir, o.cycles);
    end
  endtask

  task automatic test_pc_wrap();
    exp_t_s e; obs_t o;
    do_reset();
    plan_instr(RESET_PC, 16'h0010, 16'h0, 0, 16'h0, 1'b0, 1'b1, 16'hFFFE, e);
    observe(o);
    plan_instr(16'hFFFE, 16'h1201, 16'h0, 0, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h required 0000", pc); end
    plan_instr(16'h0000, 16'h5560, 16'h0, 0, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.ir !== 16'h5560) begin errors++; $display("FAIL wrap_fetch: got %h required 5560", o.ir); end
  endtask

  task automatic test_halt();
    exp_t_s e; obs_t o;
    logic [2:0] hs;
    do_reset();
    halt = 1'b1;
    plan_instr(RESET_PC, 16'h0010, 16'h0, 0, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.cycles !== 4) begin errors++; $display("FAIL halt_latency: got %0d required 4", o.cycles); end
    hs = state_dbg;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || exec_en !== 1'b0 || pc !== 16'h0002 || state_dbg !== hs) begin
        errors++;
        $display("FAIL halt_idle: req=%b exec=%b pc=%h, required 0 0 0002 and steady state",
                 mem_req, exec_en, pc);
      end
    end
    halt = 1'b0;
    @(posedge clk);
    #1;
    plan_instr(16'h0002, 16'h9870, 16'h0, 1, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.ir !== 16'h9870 || o.cycles !== e.cycles) begin
      errors++; $display("FAIL halt_resume: ir=%h cycles=%0d, required 9870 %0d", o.ir, o.cycles, e.cycles);
    end
  endtask

  task automatic test_reset_mid_fetch();
    exp_t_s e; obs_t o;
    do_reset();
    plan_instr(RESET_PC, 16'h1234, 16'h0, 2, 16'h0, 1'b0, 1'b0, 16'h0, e);
    repeat (5) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin
      errors++; $display("FAIL pre_reset_fh: req=%b addr=%h, required 1 0001", mem_req, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== RESET_PC || ir !== 16'h0) begin
      errors++; $display("FAIL mid_reset: req=%b pc=%h ir=%h, required 0 %h 0000", mem_req, pc, ir, RESET_PC);
    end
    do_reset();
    plan_instr(RESET_PC, 16'h5A32, 16'h0, 0, 16'h0, 1'b0, 1'b0, 16'h0, e);
    observe(o);
    checks++;
    if (o.ir !== 16'h5A32 || o.cycles !== 4) begin
      errors++; $display("FAIL post_reset: ir=%h cycles=%0d, required 5a32 4", o.ir, o.cycles);
    end
  endtask

  task automatic test_back_to_back();
    exp_t_s e; obs_t o;
    logic [15:0] mpc, word;
    int kind;
    do_reset();
    mpc = RESET_PC;
    for (int n = 0; n < 30; n++) begin
      word = 16'($urandom);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       word[3:0] = 4'($urandom_range(0, 10));
        1:       word[3:0] = 4'hB;
        2:       word[3:0] = 4'hD;
        default: word[3:0] = 4'hF;
      endcase
      plan_instr(mpc, word, 16'($urandom), $urandom_range(0, 2), 16'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom), e);
      observe(o);
      checks++;
      if (o.cycles !== e.cycles || o.ir !== e.ir || o.ext !== e.ext ||
          o.pc !== e.pc_exec || o.strobes !== e.strobes || pc !== e.pc_next) begin
        errors++;
        $display("FAIL rand_%0d: cyc=%0d ir=%h ext=%h pcx=%h stb=%0d pc=%h, required %0d %h %h %h %0d %h",
                 n, o.cycles, o.ir, o.ext, o.pc, o.strobes, pc,
                 e.cycles, e.ir, e.ext, e.pc_exec, e.strobes, e.pc_next);
      end
      mpc = e.pc_next;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL txn_leftover: %0d pending, required 0", exp_q.size()); end
  endtask

  // Main sequence
  initial begin
    checks = 0; errors = 0; hold_v = 1'b0; model_ext = 16'h0;
    reset = 1'b1; halt = 1'b0; pc_load = 1'b0; pc_value = 16'h0;
    data_addr = 16'h0; data_we = 1'b0; wait_cfg = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_plain();
    test_wait_states();
    test_special_long();
    test_mem_write();
    test_stack_wrap();
    test_pc_load();
    test_pc_wrap();
    test_halt();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
